cache_nway_ctl: RTL and testbench
=================================

Name: cache_nway_ctl

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L1 cache with an integrated controller FSM.
- Successor to the fixed 2-way cache datapath. Adds a configurable number of ways and sets, tree pseudo-LRU replacement, and an internal miss/write-back sequencer.
- Sits between the LC-3b core memory port (16-bit words) and physical memory (128-bit lines).

Parameters:
- WAYS, 2, associativity; legal values 2, 4, 8.
- SET_BITS, 3, index width; sets = 2**SET_BITS.
- Derived: offset = addr[3:0], set = addr[3+SET_BITS:4], tag = addr[15:4+SET_BITS], TAG_W = 12-SET_BITS.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_address  in  16  CPU byte address
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  2  byte lanes for writes
- mem_wdata  in  16  CPU write word
- mem_rdata  out  16  CPU read word
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  16  line-aligned physical address, [3:0]=0
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line write-back request, held until pmem_resp
- pmem_wdata  out  128  victim line
- pmem_rdata  in  128  fill line
- pmem_resp  in  1  physical memory completion

Behaviour:
- Reset (async, rst_n=0):
  - All valid, dirty and PLRU bits cleared; state=COMPARE.
  - mem_resp=0, pmem_read=0, pmem_write=0.
  - Tag and data arrays are not reset.
- Arrays read asynchronously on set index; writes occur at the clk rising edge.
- hit = OR over ways of (valid[w] & tag[w]==tag). At most one way matches.
- COMPARE state:
  - Idle when no request.
  - Request and hit:
    - mem_resp=1 combinationally in the same cycle (0-cycle hit latency).
    - Read: mem_rdata = word addr[3:1] of the hit line.
    - Write: merge mem_wdata into that word per mem_byte_enable and set the hit way's dirty bit.
    - PLRU bits on the path to the hit way are updated to point away from it.
  - Request and miss: victim way latched into a register.
    - If victim valid & dirty, go to WRITEBACK; else go to ALLOCATE.
- Victim selection: lowest-index invalid way if any, else the way indicated by the set's WAYS-1 PLRU tree bits.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, set, 4'b0}, pmem_wdata = victim line.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address={tag, set, 4'b0}.
  - On pmem_resp: victim data=pmem_rdata, tag loaded, valid=1, dirty=0; return to COMPARE.
  - The request then completes as a hit.
- mem_resp is never asserted in WRITEBACK or ALLOCATE.
- mem_read and mem_write both high: treated as a write; mem_rdata is don't-care.
- mem_byte_enable=2'b00 on a write: no data change, but dirty is still set and mem_resp is still pulsed.
- Request dropped mid-miss: the sequence completes regardless, the line is installed, and no mem_resp is issued.
- Reset mid-miss: pmem_read/pmem_write deassert immediately and the partially filled line is not validated.
- PLRU encoding: node bit 0 means the victim is in the lower half. Accessing a way sets the bits on its path to point to the other half.

Optional Feature:
- Macro: CACHE_NWAY_PERF_CNT_EN.
- Defined:
  - Adds output ports hit_count[15:0], miss_count[15:0] and wb_count[15:0], each cleared on reset.
  - hit_count increments on a COMPARE hit that is not the completion of a miss.
  - miss_count increments on COMPARE→WRITEBACK/ALLOCATE.
  - wb_count increments on WRITEBACK exit.
  - All counters saturate at 16'hFFFF.
- Undefined: the ports and logic are absent; functional behaviour is identical.

Test Plan:
- Cold read miss (WAYS=2, SET_BITS=3), read 0x1234 with memory line 0x1230 = 128'h…_BEEF at word 2:
  - Expect pmem_read, address 0x1230, no pmem_write.
  - Expect mem_resp one cycle after pmem_resp with mem_rdata=0xBEEF.
- Write hit: write 0x1234 data 0xA55A, byte_enable 2'b01:
  - mem_resp in the same cycle; a following read returns {0xBE,0x5A}; dirty set.
- Conflict eviction in set 3:
  - Fill 0x1234 (tag 0x24) and 0x12B4 (tag 0x25), dirty 0x1234, touch 0x12B4, then read 0x1334.
  - Expect pmem_write to 0x1230 with the modified line, then pmem_read 0x1330.
  - A later read of 0x12B4 hits.
- Clean victim: repeat the previous scenario without the write → no pmem_write, only pmem_read.
- Async reset asserted while pmem_read=1:
  - pmem_read drops without a clock edge.
  - After release, read 0x1234 misses again.
- WAYS=4 PLRU:
  - Fill 4 tags in set 0, then access ways 0,1,2,3 in order; the next miss evicts way 0.
  - With CACHE_NWAY_PERF_CNT_EN defined: miss_count=5, hit_count=4.

Source files
------------

// File: rtl/cache_nway_ctl.sv
// N-way set-associative write-back, write-allocate L1 cache with tree pseudo-LRU and miss sequencer.
// Optional hit/miss/write-back counters are built when CACHE_NWAY_PERF_CNT_EN is defined.
module cache_nway_ctl #(
    parameter int unsigned WAYS     = 2,
    parameter int unsigned SET_BITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef CACHE_NWAY_PERF_CNT_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count,
    output logic [15:0]  wb_count
`endif
);

    localparam int unsigned SETS  = 1 << SET_BITS;
    localparam int unsigned TAG_W = 12 - SET_BITS;
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned NODES = WAYS - 1;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_e;

    state_e state_q, state_d;

    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    valid_d [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [WAYS-1:0]    dirty_d [SETS];
    logic [NODES-1:0]   plru_q  [SETS];
    logic [NODES-1:0]   plru_d  [SETS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [127:0]       data_q  [SETS][WAYS];

    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [SET_BITS-1:0] miss_set_q, miss_set_d;
    logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;

    logic [SET_BITS-1:0] set_a;
    logic [TAG_W-1:0]    tag_a;
    logic [2:0]          word_sel;
    logic                req;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    plru_way;
    logic [WAY_W-1:0]    victim_sel;
    logic                path_ok;
    logic [127:0]        hit_line;

    logic                tag_we;
    logic                data_we;
    logic [SET_BITS-1:0] wr_set;
    logic [WAY_W-1:0]    wr_way;
    logic [127:0]        wr_line;

    logic                unused_addr_bit;

    assign set_a           = mem_address[3+SET_BITS:4];
    assign tag_a           = mem_address[15:4+SET_BITS];
    assign word_sel        = mem_address[3:1];
    assign req             = mem_read | mem_write;
    assign hit_line        = data_q[set_a][hit_way];
    assign unused_addr_bit = mem_address[0];

    // Tag match across the ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_a][w] && (tag_q[set_a][w] == tag_a)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, otherwise the way whose path matches every tree bit.
    always_comb begin
        plru_way = '0;
        path_ok  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            path_ok = 1'b1;
            for (int l = 0; l < WAY_W; l++) begin
                if (plru_q[set_a][(1 << l) - 1 + (w >> (WAY_W - l))] != w[WAY_W-1-l]) begin
                    path_ok = 1'b0;
                end
            end
            if (path_ok) begin
                plru_way = WAY_W'(w);
            end
        end
        victim_sel = plru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_a][w]) begin
                victim_sel = WAY_W'(w);
            end
        end
    end

    // Array update: hit-path PLRU/dirty/word merge, or line install at fill completion.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        plru_d  = plru_q;
        tag_we  = 1'b0;
        data_we = 1'b0;
        wr_set  = set_a;
        wr_way  = hit_way;
        wr_line = hit_line;
        if (mem_byte_enable[0]) begin
            wr_line[{word_sel, 4'h0} +: 8] = mem_wdata[7:0];
        end
        if (mem_byte_enable[1]) begin
            wr_line[{word_sel, 4'h8} +: 8] = mem_wdata[15:8];
        end
        if ((state_q == COMPARE) && req && hit) begin
            for (int l = 0; l < WAY_W; l++) begin
                for (int n = 0; n < NODES; n++) begin
                    if (n == (1 << l) - 1 + (hit_way >> (WAY_W - l))) begin
                        plru_d[set_a][n] = ~hit_way[WAY_W-1-l];
                    end
                end
            end
            if (mem_write) begin
                data_we                 = 1'b1;
                dirty_d[set_a][hit_way] = 1'b1;
            end
        end else if ((state_q == ALLOCATE) && pmem_resp) begin
            tag_we                        = 1'b1;
            data_we                       = 1'b1;
            wr_set                        = miss_set_q;
            wr_way                        = victim_q;
            wr_line                       = pmem_rdata;
            valid_d[miss_set_q][victim_q] = 1'b1;
            dirty_d[miss_set_q][victim_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[wr_set][wr_way] <= miss_tag_q;
        end
        if (data_we) begin
            data_q[wr_set][wr_way] <= wr_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COMPARE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_q   <= '0;
            miss_set_q <= '0;
            miss_tag_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            victim_q   <= victim_d;
            miss_set_q <= miss_set_d;
            miss_tag_q <= miss_tag_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            plru_q     <= plru_d;
        end
    end

    // Next state; the miss context is latched so a dropped request still completes.
    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        miss_set_d = miss_set_q;
        miss_tag_d = miss_tag_q;
        case (state_q)
            COMPARE: begin
                if (req && !hit) begin
                    victim_d   = victim_sel;
                    miss_set_d = set_a;
                    miss_tag_d = tag_a;
                    state_d    = (valid_q[set_a][victim_sel] && dirty_q[set_a][victim_sel])
                                 ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: if (pmem_resp) state_d = ALLOCATE;
            ALLOCATE:  if (pmem_resp) state_d = COMPARE;
            default:   state_d = COMPARE;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = hit_line[{word_sel, 4'h0} +: 16];
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {miss_tag_q, miss_set_q, 4'h0};
        pmem_wdata   = data_q[miss_set_q][victim_q];
        case (state_q)
            COMPARE:   mem_resp = req & hit;
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[miss_set_q][victim_q], miss_set_q, 4'h0};
            end
            ALLOCATE:  pmem_read = 1'b1;
            default:   mem_resp = 1'b0;
        endcase
    end

`ifdef CACHE_NWAY_PERF_CNT_EN
    logic        fill_done_q, fill_done_d;
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;
    logic [15:0] wb_count_q, wb_count_d;

    // Saturating event counters; the hit that completes a miss is not counted.
    always_comb begin
        fill_done_d  = (state_q == ALLOCATE) && pmem_resp;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        if ((state_q == COMPARE) && req && hit && !fill_done_q && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if ((state_q == COMPARE) && req && !hit && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
        if ((state_q == WRITEBACK) && pmem_resp && (wb_count_q != 16'hFFFF)) begin
            wb_count_d = wb_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_done_q  <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            fill_done_q  <= fill_done_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_cache_nway_ctl.sv
// Directed self-checking bench: a 2-way instance for miss/hit/eviction/reset cases and a 4-way instance for PLRU order.
module tb_cache_nway_ctl;

    logic         clk;
    logic         rst_n;
    logic [15:0]  mem_address     [2];
    logic         mem_read        [2];
    logic         mem_write       [2];
    logic [1:0]   mem_byte_enable [2];
    logic [15:0]  mem_wdata       [2];
    logic [15:0]  mem_rdata       [2];
    logic         mem_resp        [2];
    logic [15:0]  pmem_address    [2];
    logic         pmem_read       [2];
    logic         pmem_write      [2];
    logic [127:0] pmem_wdata      [2];
    logic [127:0] pmem_rdata      [2];
    logic         pmem_resp       [2];
`ifdef CACHE_NWAY_PERF_CNT_EN
    logic [15:0]  hit_count  [2];
    logic [15:0]  miss_count [2];
    logic [15:0]  wb_count   [2];
`endif

    int n_checks;
    int n_errors;

    int           rd_cnt  [2];
    int           wb_cnt  [2];
    logic [15:0]  rd_addr [2];
    logic [15:0]  wb_addr [2];
    logic [127:0] wb_data [2];
    logic [127:0] mem [logic [11:0]];

    localparam int MEM_LAT = 1;

    cache_nway_ctl #(.WAYS(2), .SET_BITS(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .mem_address(mem_address[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .mem_byte_enable(mem_byte_enable[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_resp(mem_resp[0]),
        .pmem_address(pmem_address[0]), .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]),
        .pmem_wdata(pmem_wdata[0]), .pmem_rdata(pmem_rdata[0]), .pmem_resp(pmem_resp[0])
`ifdef CACHE_NWAY_PERF_CNT_EN
        , .hit_count(hit_count[0]), .miss_count(miss_count[0]), .wb_count(wb_count[0])
`endif
    );

    cache_nway_ctl #(.WAYS(4), .SET_BITS(3)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .mem_address(mem_address[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .mem_byte_enable(mem_byte_enable[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_resp(mem_resp[1]),
        .pmem_address(pmem_address[1]), .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]),
        .pmem_wdata(pmem_wdata[1]), .pmem_rdata(pmem_rdata[1]), .pmem_resp(pmem_resp[1])
`ifdef CACHE_NWAY_PERF_CNT_EN
        , .hit_count(hit_count[1]), .miss_count(miss_count[1]), .wb_count(wb_count[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default line contents: word k of line la is {la, k}.
    function automatic logic [127:0] pat(input logic [11:0] la);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) begin
            l[k*16 +: 16] = {la, 4'(k)};
        end
        return l;
    endfunction

    function automatic logic [127:0] line_at(input logic [11:0] la);
        if (mem.exists(la)) return mem[la];
        return pat(la);
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU request on instance d; cyc is the number of negedges before mem_resp was seen.
    task automatic access(input int d, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic [1:0] be, output logic [15:0] rd, output int cyc);
        mem_address[d]     = a;
        mem_write[d]       = wr;
        mem_read[d]        = !wr;
        mem_wdata[d]       = wd;
        mem_byte_enable[d] = be;
        cyc = -1;
        rd  = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_resp[d]) begin
                cyc = i;
                rd  = mem_rdata[d];
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        check_eq("resp_seen", 128'(cyc >= 0), 128'(1));
    endtask

    // Physical memory model with MEM_LAT wait cycles before a one-cycle pmem_resp.
    initial begin : mem_model
        int lat [2];
        logic [127:0] l;
        l = pat(12'h123);
        l[47:32] = 16'hBEEF;
        mem[12'h123] = l;
        for (int g = 0; g < 2; g++) begin
            lat[g] = 0; pmem_resp[g] = 1'b0; pmem_rdata[g] = '0;
            rd_cnt[g] = 0; wb_cnt[g] = 0; rd_addr[g] = '0; wb_addr[g] = '0; wb_data[g] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                pmem_resp[g] = 1'b0;
                if (rst_n && (pmem_read[g] || pmem_write[g])) begin
                    if (lat[g] == MEM_LAT) begin
                        lat[g]       = 0;
                        pmem_resp[g] = 1'b1;
                        if (pmem_write[g]) begin
                            mem[pmem_address[g][15:4]] = pmem_wdata[g];
                            wb_cnt[g]++;
                            wb_addr[g] = pmem_address[g];
                            wb_data[g] = pmem_wdata[g];
                        end else begin
                            pmem_rdata[g] = line_at(pmem_address[g][15:4]);
                            rd_cnt[g]++;
                            rd_addr[g] = pmem_address[g];
                        end
                    end else begin
                        lat[g]++;
                    end
                end else begin
                    lat[g] = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [15:0]  rd;
        logic [127:0] exp_line;
        int           cyc;
        logic         ok;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mem_address[d] = '0; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
            mem_byte_enable[d] = 2'b00; mem_wdata[d] = '0;
        end
        #3;
        check_eq("rst_mem_resp", 128'(mem_resp[0]), 128'(0));
        check_eq("rst_pmem_read", 128'(pmem_read[0]), 128'(0));
        check_eq("rst_pmem_write", 128'(pmem_write[0]), 128'(0));
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold read miss
        access(0, 1'b0, 16'h1234, 16'h0, 2'b00, rd, cyc);
        check_eq("cold_rdata", 128'(rd), 128'(16'hBEEF));
        check_eq("cold_latency", 128'(cyc), 128'(3));
        check_eq("cold_pmem_addr", 128'(rd_addr[0]), 128'(16'h1230));
        check_eq("cold_rd_cnt", 128'(rd_cnt[0]), 128'(1));
        check_eq("cold_no_wb", 128'(wb_cnt[0]), 128'(0));

        // Write hit, low byte only, then read back
        access(0, 1'b1, 16'h1234, 16'hA55A, 2'b01, rd, cyc);
        check_eq("wr_hit_latency", 128'(cyc), 128'(0));
        access(0, 1'b0, 16'h1234, 16'h0, 2'b00, rd, cyc);
        check_eq("wr_readback", 128'(rd), 128'(16'hBE5A));
        check_eq("wr_readback_latency", 128'(cyc), 128'(0));

        // Second line in set 3, touched, then a conflicting dirty eviction
        access(0, 1'b0, 16'h12B4, 16'h0, 2'b00, rd, cyc);
        check_eq("fill2_rdata", 128'(rd), 128'(16'h12B2));
        check_eq("fill2_pmem_addr", 128'(rd_addr[0]), 128'(16'h12B0));
        access(0, 1'b0, 16'h12B4, 16'h0, 2'b00, rd, cyc);
        check_eq("touch_latency", 128'(cyc), 128'(0));
        access(0, 1'b0, 16'h1334, 16'h0, 2'b00, rd, cyc);
        exp_line = pat(12'h123);
        exp_line[47:32] = 16'hBE5A;
        check_eq("evict_rdata", 128'(rd), 128'(16'h1332));
        check_eq("evict_latency", 128'(cyc), 128'(5));
        check_eq("evict_wb_cnt", 128'(wb_cnt[0]), 128'(1));
        check_eq("evict_wb_addr", 128'(wb_addr[0]), 128'(16'h1230));
        check_eq("evict_wb_data", wb_data[0], exp_line);
        check_eq("evict_fill_addr", 128'(rd_addr[0]), 128'(16'h1330));
        access(0, 1'b0, 16'h12B4, 16'h0, 2'b00, rd, cyc);
        check_eq("survivor_hit_latency", 128'(cyc), 128'(0));
        check_eq("survivor_rdata", 128'(rd), 128'(16'h12B2));

        // Clean victim: 0x1334 is clean and least recently used
        access(0, 1'b0, 16'h12B4, 16'h0, 2'b00, rd, cyc);
        access(0, 1'b0, 16'h1234, 16'h0, 2'b00, rd, cyc);
        check_eq("clean_latency", 128'(cyc), 128'(3));
        check_eq("clean_no_wb", 128'(wb_cnt[0]), 128'(1));
        check_eq("clean_fill_addr", 128'(rd_addr[0]), 128'(16'h1230));
        check_eq("clean_rdata_from_wb", 128'(rd), 128'(16'hBE5A));

        // Write with no byte lanes: data unchanged but the line still becomes dirty
        access(0, 1'b1, 16'h12B4, 16'hFFFF, 2'b00, rd, cyc);
        check_eq("be00_latency", 128'(cyc), 128'(0));
        access(0, 1'b0, 16'h12B4, 16'h0, 2'b00, rd, cyc);
        check_eq("be00_rdata", 128'(rd), 128'(16'h12B2));
        access(0, 1'b0, 16'h1234, 16'h0, 2'b00, rd, cyc);
        access(0, 1'b0, 16'h1334, 16'h0, 2'b00, rd, cyc);
        check_eq("be00_dirty_wb_cnt", 128'(wb_cnt[0]), 128'(2));
        check_eq("be00_dirty_wb_addr", 128'(wb_addr[0]), 128'(16'h12B0));
        check_eq("be00_dirty_wb_data", wb_data[0], pat(12'h12B));

        // Asynchronous reset while a fill is outstanding
        mem_address[0] = 16'h1634;
        mem_read[0]    = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #3;
            if (pmem_read[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("midmiss_pmem_read_up", 128'(ok), 128'(1));
        rst_n = 1'b0;
        #1;
        check_eq("midmiss_async_drop", 128'(pmem_read[0]), 128'(0));
        mem_read[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1'b0, 16'h1234, 16'h0, 2'b00, rd, cyc);
        check_eq("post_rst_miss_latency", 128'(cyc), 128'(3));
        check_eq("post_rst_rdata", 128'(rd), 128'(16'hBE5A));

        // 4-way PLRU: fill set 0, touch ways 0..3, next miss must evict way 0
        for (int t = 0; t < 4; t++) begin
            access(1, 1'b0, 16'(t * 16'h0080), 16'h0, 2'b00, rd, cyc);
            check_eq("w4_fill_latency", 128'(cyc), 128'(3));
            check_eq("w4_fill_rdata", 128'(rd), 128'(t * 16'h0080));
        end
        for (int t = 0; t < 4; t++) begin
            access(1, 1'b0, 16'(t * 16'h0080), 16'h0, 2'b00, rd, cyc);
            check_eq("w4_touch_latency", 128'(cyc), 128'(0));
        end
        access(1, 1'b0, 16'h0200, 16'h0, 2'b00, rd, cyc);
        check_eq("w4_new_latency", 128'(cyc), 128'(3));
        check_eq("w4_new_rdata", 128'(rd), 128'(16'h0200));
`ifdef CACHE_NWAY_PERF_CNT_EN
        check_eq("w4_miss_count", 128'(miss_count[1]), 128'(5));
        check_eq("w4_hit_count", 128'(hit_count[1]), 128'(4));
        check_eq("w4_wb_count", 128'(wb_count[1]), 128'(0));
`endif
        for (int t = 1; t < 5; t++) begin
            access(1, 1'b0, 16'(t * 16'h0080), 16'h0, 2'b00, rd, cyc);
            check_eq("w4_kept_latency", 128'(cyc), 128'(0));
        end
        access(1, 1'b0, 16'h0000, 16'h0, 2'b00, rd, cyc);
        check_eq("w4_evicted_way0_latency", 128'(cyc), 128'(3));
        check_eq("w4_no_wb", 128'(wb_cnt[1]), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
